line_fetch_responder: RTL and testbench
=======================================

// Module: line_fetch_responder
// PURPOSE
// - Services the row-fetch request issued by the composite pixel stage: on a
//   mem_readstrobe it reads one 256-pixel line (32 bytes) from the byte-wide
//   frame RAM starting at mem_addrin.
// - Unpacks each byte MSB-first into the 1-bit line cache at cache addresses
//   0..255. Drives mem_ready low while the line is being filled.
// - Sits between the RAM controller and the line cache write port; the pixel
//   stage owns the cache read port.
// PARAMETERS
// - BYTES_PER_LINE  32  bytes fetched per request (pixels = 8*BYTES_PER_LINE)
// - CACHE_AW        9   cache address width; bits above log2(8*BYTES_PER_LINE) driven 0
// PORTS
// - sys_clk         in   1        single clock, all logic on posedge
// - sys_rst         in   1        synchronous, active-high reset
// - mem_addrin      in   16       line start byte address, sampled at accept
// - mem_readstrobe  in   1        fetch request level; may be held several cycles
// - mem_ready       out  1        1 = idle, can accept; 0 = fill in progress
// - ram_rd_req      out  1        one-cycle read request to RAM controller
// - ram_addr        out  16       byte address, valid when ram_rd_req = 1
// - ram_rd_valid    in   1        one-cycle pulse, ram_rd_data valid
// - ram_rd_data     in   8        read byte
// - cache_wren      out  1        line cache write enable
// - cache_addrin    out  CACHE_AW cache write address
// - cache_in        out  1        pixel bit written
// BEHAVIOUR
// - Reset values: mem_ready=1, ram_rd_req=0, ram_addr=0, cache_wren=0,
//   cache_addrin=0, cache_in=0. FSM goes to IDLE. Byte and bit counters = 0.
// - Accept: rising edge of mem_readstrobe (registered previous value) while in
//   IDLE. Latch mem_addrin into base, clear byte_idx, go to REQ.
//   mem_ready=0 on the next cycle.
// - Strobe held high or re-asserted while busy: ignored. After the fill
//   completes, a still-high strobe does not retrigger; a new rising edge is
//   required.
// - FSM:
//   - IDLE  -> REQ on accept.
//   - REQ   drives ram_rd_req=1 for exactly one cycle, with
//     ram_addr = base + byte_idx (16-bit wrap, 0xFFFF+1 = 0x0000) -> WAIT.
//   - WAIT  holds until ram_rd_valid. Latch ram_rd_data into the shift
//     register, bit=0 -> SHIFT. A ram_rd_valid seen outside WAIT is ignored.
//   - SHIFT emits one bit per cycle for 8 cycles: cache_wren=1,
//     cache_in = shreg[7-bit], cache_addrin = {byte_idx, bit[2:0]}.
//     After bit 7: if byte_idx = BYTES_PER_LINE-1 -> DONE, else byte_idx++ -> REQ.
//   - DONE  mem_ready=1 next cycle -> IDLE. cache_wren=0.
// - Timing: minimum time from accept to mem_ready high is
//   BYTES_PER_LINE*(2 + L + 8) + 2 cycles, where L = RAM latency
//   (ram_rd_req to ram_rd_valid).
// - cache_wren is 0 in every state except SHIFT. Each of the 256 cache
//   addresses is written exactly once per fetch, in ascending order.
// - Reset mid-fill aborts immediately: no further cache writes or RAM requests,
//   and the reset values above apply. A ram_rd_valid from the aborted request
//   that arrives after reset is ignored.
// - Simultaneous ram_rd_valid and sys_rst: reset wins.
// STRUCTURE
// - Shared package line_fetch_pkg: FSM state encoding (IDLE, REQ, WAIT, SHIFT,
//   DONE), LINE_BYTES=32, LINE_PIXELS=256.
// - One natural sub-module: byte_serializer. It loads an 8-bit value and shifts
//   it out MSB-first with bit index and a done flag. The FSM, address adder and
//   handshake logic stay in the top module.
// TESTING
// - Reset then idle: mem_ready=1, cache_wren=0, no ram_rd_req for 100 cycles.
// - Fetch at 0x0020 with a RAM model of latency 3 returning data = addr[7:0]:
//   - 32 ram_rd_req at 0x0020..0x003F;
//   - cache bits 0..7 = 0x20 MSB-first (00100000);
//   - address 255 holds bit0 of 0x3F (1);
//   - mem_ready high 32*13+2 cycles after accept.
// - mem_readstrobe held high for 4 cycles, then re-pulsed mid-fill ->
//   exactly 32 RAM requests, one fill; strobe still high at completion ->
//   no second fill.
// - Base 0xFFF0 -> ram_addr sequence 0xFFF0..0xFFFF, then 0x0000..0x000F.
// - sys_rst asserted during SHIFT of byte 10 -> next cycle mem_ready=1 and
//   cache_wren=0. A late ram_rd_valid is ignored. A new strobe then fills from
//   byte 0.
// - Random RAM latency 0..20 cycles over 50 fetches -> cache contents match
//   the RAM model and each cache address is written exactly once per fetch.

Source files
------------

// File: rtl/line_fetch_pkg.sv
// line_fetch_pkg: FSM state encoding and line geometry shared by the line fetch responder
package line_fetch_pkg;
  localparam int LINE_BYTES = 32;
  localparam int LINE_PIXELS = 8 * LINE_BYTES;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, SHIFT, DONE} state_t;
endpackage

// File: rtl/line_fetch_responder_if.sv
// line_fetch_responder_if: fetch handshake, RAM read port and line cache write port
//   slave  (responder): takes mem_addrin/mem_readstrobe/ram_rd_valid/ram_rd_data,
//                       drives mem_ready/ram_rd_req/ram_addr/cache_wren/cache_addrin/cache_in
//   master (environment): the mirror image
interface line_fetch_responder_if #(
  parameter int CACHE_AW = 9
) ();
  logic [15:0] mem_addrin;
  logic mem_readstrobe;
  logic mem_ready;
  logic ram_rd_req;
  logic [15:0] ram_addr;
  logic ram_rd_valid;
  logic [7:0] ram_rd_data;
  logic cache_wren;
  logic [CACHE_AW-1:0] cache_addrin;
  logic cache_in;
  modport slave (
    input mem_addrin, mem_readstrobe, ram_rd_valid, ram_rd_data,
    output mem_ready, ram_rd_req, ram_addr, cache_wren, cache_addrin, cache_in
  );
  modport master (
    output mem_addrin, mem_readstrobe, ram_rd_valid, ram_rd_data,
    input mem_ready, ram_rd_req, ram_addr, cache_wren, cache_addrin, cache_in
  );
endinterface

// File: rtl/byte_serializer.sv
// byte_serializer: loads a byte and shifts it out MSB-first with bit index and last-bit flag
//   sys_clk/sys_rst: clock, sync active-high reset; load/din: capture byte; shift: advance one bit
//   bit_out: current bit (registered MSB); bit_idx: bits already emitted; done: emitting bit 7
module byte_serializer (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       load,
  input  logic       shift,
  input  logic [7:0] din,
  output logic       bit_out,
  output logic [2:0] bit_idx,
  output logic       done
);
  logic [7:0] shreg;
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      shreg <= '0;
      bit_idx <= '0;
    end else if (load) begin
      shreg <= din;
      bit_idx <= '0;
    end else if (shift) begin
      shreg <= {shreg[6:0], 1'b0};
      bit_idx <= bit_idx + 3'd1;
    end
  assign bit_out = shreg[7];
  assign done = bit_idx == 3'd7;
endmodule

// File: rtl/line_fetch_responder.sv
// line_fetch_responder: fetches one line of bytes from frame RAM and unpacks it MSB-first into the 1-bit line cache
//   sys_clk/sys_rst: clock, sync active-high reset
//   bus (slave): mem_addrin/mem_readstrobe/mem_ready fetch handshake, ram_rd_req/ram_addr/ram_rd_valid/ram_rd_data
//                RAM read port, cache_wren/cache_addrin/cache_in cache write port
module line_fetch_responder
  import line_fetch_pkg::*;
#(
  parameter int BYTES_PER_LINE = LINE_BYTES,
  parameter int CACHE_AW = $clog2(LINE_PIXELS) + 1
) (
  input logic sys_clk,
  input logic sys_rst,
  line_fetch_responder_if.slave bus
);
  localparam int BW = $clog2(BYTES_PER_LINE);
  localparam logic [BW-1:0] LAST = BW'(BYTES_PER_LINE - 1);
  state_t state;
  logic strobe_q;
  logic [15:0] base;
  logic [BW-1:0] byte_idx;
  logic [2:0] bit_idx;
  logic ser_bit, ser_done, accept, load, shift;
  // only a fresh rising edge starts a fill, so a strobe still high after completion cannot retrigger
  assign accept = state == IDLE && bus.mem_readstrobe && !strobe_q;
  assign load = state == WAIT && bus.ram_rd_valid;
  assign shift = state == SHIFT;
  byte_serializer u_ser (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .load(load),
    .shift(shift),
    .din(bus.ram_rd_data),
    .bit_out(ser_bit),
    .bit_idx(bit_idx),
    .done(ser_done)
  );
  assign bus.cache_in = ser_bit;
  assign bus.cache_addrin = CACHE_AW'({byte_idx, bit_idx});
  always_ff @(posedge sys_clk)
    if (sys_rst) begin
      state <= IDLE;
      strobe_q <= 1'b0;
      base <= '0;
      byte_idx <= '0;
      bus.mem_ready <= 1'b1;
      bus.ram_rd_req <= 1'b0;
      bus.ram_addr <= '0;
      bus.cache_wren <= 1'b0;
    end else begin
      strobe_q <= bus.mem_readstrobe;
      bus.ram_rd_req <= 1'b0;
      case (state)
        IDLE: if (accept) begin
          base <= bus.mem_addrin;
          byte_idx <= '0;
          bus.mem_ready <= 1'b0;
          bus.ram_rd_req <= 1'b1;
          bus.ram_addr <= bus.mem_addrin;
          state <= REQ;
        end
        REQ: state <= WAIT;
        WAIT: if (bus.ram_rd_valid) begin
          bus.cache_wren <= 1'b1;
          state <= SHIFT;
        end
        SHIFT: if (ser_done) begin
          bus.cache_wren <= 1'b0;
          if (byte_idx == LAST) state <= DONE;
          else begin
            byte_idx <= byte_idx + BW'(1);
            bus.ram_rd_req <= 1'b1;
            bus.ram_addr <= base + 16'(byte_idx) + 16'd1;
            state <= REQ;
          end
        end
        DONE: begin
          bus.mem_ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_line_fetch_responder.sv
// tb_line_fetch_responder: directed and random line fetches against a latency-configurable RAM model with a cache-write scoreboard
module tb_line_fetch_responder;
  import line_fetch_pkg::*;
  logic sys_clk = 1'b0;
  logic sys_rst = 1'b1;
  line_fetch_responder_if #(.CACHE_AW(9)) bus ();
  line_fetch_responder #(.BYTES_PER_LINE(32), .CACHE_AW(9)) dut (
    .sys_clk(sys_clk),
    .sys_rst(sys_rst),
    .bus(bus)
  );
  initial forever #5 sys_clk = ~sys_clk;
  int errors = 0;
  int checks = 0;
  int lat = 0;
  int cnt = 0;
  int wr_total = 0;
  bit pend = 1'b0;
  bit inj = 1'b0;
  logic [7:0] key = '0;
  logic [15:0] cur_base = '0;
  logic [15:0] paddr = '0;
  logic [9:0] sbq[$];
  logic [15:0] reqs[$];
  int wcnt[LINE_PIXELS];
  logic cache_m[LINE_PIXELS];
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    logic [7:0] d;
    logic [15:0] idx;
    logic [9:0] e;
    @(posedge sys_clk);
    #1;
    bus.ram_rd_valid = 1'b0;
    if (sys_rst) pend = 1'b0;
    else if (pend && cnt == 0) begin
      d = paddr[7:0] ^ key;
      bus.ram_rd_valid = 1'b1;
      bus.ram_rd_data = d;
      pend = 1'b0;
      idx = paddr - cur_base;
      for (int b = 0; b < 8; b++) sbq.push_back({1'b0, idx[4:0], 3'(b), d[7-b]});
    end else if (pend) cnt--;
    if (inj) begin
      bus.ram_rd_valid = 1'b1;
      bus.ram_rd_data = 8'hFF;
      inj = 1'b0;
    end
    if (bus.ram_rd_req) begin
      reqs.push_back(bus.ram_addr);
      pend = 1'b1;
      paddr = bus.ram_addr;
      cnt = lat;
    end
    if (bus.cache_wren) begin
      wr_total++;
      chk("sb_nonempty", 32'(sbq.size() != 0), 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("cache_addr", 32'(bus.cache_addrin), 32'(e[9:1]));
        chk("cache_bit", 32'(bus.cache_in), 32'(e[0]));
      end
      wcnt[bus.cache_addrin[7:0]]++;
      cache_m[bus.cache_addrin[7:0]] = bus.cache_in;
    end
  endtask
  task automatic start(input logic [15:0] b);
    cur_base = b;
    reqs.delete();
    sbq.delete();
    foreach (wcnt[i]) wcnt[i] = 0;
    bus.mem_addrin = b;
    bus.mem_readstrobe = 1'b1;
  endtask
  task automatic run_wait(input int exp_n, input bit hold);
    int n = 0;
    int bad = 0;
    do begin
      tick();
      n++;
      if (!hold) bus.mem_readstrobe = 1'b0;
    end while (!bus.mem_ready && n < 1200);
    chk("fill_done", 32'(bus.mem_ready), 32'd1);
    if (exp_n > 0) chk("ready_latency", 32'(n), 32'(exp_n));
    chk("req_count", 32'(reqs.size()), 32'd32);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    foreach (wcnt[i]) if (wcnt[i] != 1) bad++;
    chk("write_once", 32'(bad), 32'd0);
  endtask
  initial begin
    int bad;
    int w0;
    int n;
    logic [7:0] v;
    bus.mem_addrin = '0;
    bus.mem_readstrobe = 1'b0;
    bus.ram_rd_valid = 1'b0;
    bus.ram_rd_data = '0;
    repeat (2) tick();
    chk("rst_ready", 32'(bus.mem_ready), 32'd1);
    chk("rst_req", 32'(bus.ram_rd_req), 32'd0);
    chk("rst_addr", 32'(bus.ram_addr), 32'd0);
    chk("rst_wren", 32'(bus.cache_wren), 32'd0);
    chk("rst_caddr", 32'(bus.cache_addrin), 32'd0);
    chk("rst_cin", 32'(bus.cache_in), 32'd0);
    sys_rst = 1'b0;
    reqs.delete();
    w0 = wr_total;
    bad = 0;
    repeat (100) begin
      tick();
      if (!bus.mem_ready) bad++;
    end
    chk("idle_ready", 32'(bad), 32'd0);
    chk("idle_req", 32'(reqs.size()), 32'd0);
    chk("idle_wr", 32'(wr_total - w0), 32'd0);
    lat = 3;
    key = 8'h00;
    start(16'h0020);
    run_wait(32 * 13 + 2, 1'b0);
    for (int i = 0; i < reqs.size(); i++) chk("req_addr", 32'(reqs[i]), 32'h20 + 32'(i));
    for (int b = 0; b < 8; b++) v[7-b] = cache_m[b];
    chk("line_byte0", 32'(v), 32'h20);
    chk("pix255", 32'(cache_m[255]), 32'd1);
    lat = 1;
    key = 8'h5A;
    start(16'h1234);
    repeat (4) tick();
    bus.mem_readstrobe = 1'b0;
    repeat (40) tick();
    bus.mem_readstrobe = 1'b1;
    run_wait(0, 1'b1);
    repeat (20) tick();
    chk("no_retrigger", 32'(reqs.size()), 32'd32);
    chk("ready_held", 32'(bus.mem_ready), 32'd1);
    bus.mem_readstrobe = 1'b0;
    tick();
    lat = 2;
    key = 8'hC3;
    start(16'hFFF0);
    run_wait(32 * 12 + 2, 1'b0);
    for (int i = 0; i < reqs.size(); i++) chk("wrap_addr", 32'(reqs[i]), 32'(16'(16'hFFF0 + i)));
    chk("wrap_zero", 32'(reqs[16]), 32'd0);
    lat = 1;
    key = 8'h0F;
    start(16'h0100);
    n = 0;
    do begin
      tick();
      n++;
      bus.mem_readstrobe = 1'b0;
    end while (!(bus.cache_wren && bus.cache_addrin[7:3] == 5'd10) && n < 1200);
    chk("reach_byte10", 32'(bus.cache_addrin[7:3]), 32'd10);
    repeat (3) tick();
    sys_rst = 1'b1;
    tick();
    chk("abort_ready", 32'(bus.mem_ready), 32'd1);
    chk("abort_wren", 32'(bus.cache_wren), 32'd0);
    chk("abort_req", 32'(bus.ram_rd_req), 32'd0);
    chk("abort_caddr", 32'(bus.cache_addrin), 32'd0);
    sys_rst = 1'b0;
    sbq.delete();
    reqs.delete();
    w0 = wr_total;
    inj = 1'b1;
    repeat (10) tick();
    chk("late_valid_wr", 32'(wr_total - w0), 32'd0);
    chk("post_rst_req", 32'(reqs.size()), 32'd0);
    chk("post_rst_ready", 32'(bus.mem_ready), 32'd1);
    start(16'h0200);
    run_wait(32 * 11 + 2, 1'b0);
    chk("refill_first", 32'(reqs[0]), 32'h0200);
    for (int f = 0; f < 50; f++) begin
      lat = $urandom_range(0, 20);
      key = 8'($urandom);
      start(16'($urandom));
      run_wait(32 * (10 + lat) + 2, 1'b0);
      chk("rand_last_addr", 32'(reqs[31]), 32'(16'(cur_base + 16'd31)));
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
